// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encodings and default widths for the sequenced ALU.
package alu_seq_pkg;

  localparam int NB_OP_DEF = 6;

  // MIPS funct-style opcodes
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

endpackage

// File: rtl/load_debounce.sv
// Load button conditioning: 2-flop synchroniser, stability counter, and
// rising-edge detector producing a single-cycle pulse per debounced press.
module load_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          edge_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the synchroniser chain relies on.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      edge_q  <= db_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign o_pulse = db_q & ~edge_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Button-sequenced ALU: capture A, B and opcode on successive debounced load
// presses, execute once, then display the registered result and flags.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = NB_OP_DEF,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_dato,
  input  logic               i_load,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err,
  output logic               o_valid,
  output logic [2:0]         o_state
);

  localparam int MSB = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] SHAMT_LIMIT = NB_DATA'(NB_DATA);

  localparam logic [NB_OP-1:0] C_ADD = NB_OP'(OP_ADD);
  localparam logic [NB_OP-1:0] C_SUB = NB_OP'(OP_SUB);
  localparam logic [NB_OP-1:0] C_AND = NB_OP'(OP_AND);
  localparam logic [NB_OP-1:0] C_OR  = NB_OP'(OP_OR);
  localparam logic [NB_OP-1:0] C_XOR = NB_OP'(OP_XOR);
  localparam logic [NB_OP-1:0] C_NOR = NB_OP'(OP_NOR);
  localparam logic [NB_OP-1:0] C_SRA = NB_OP'(OP_SRA);
  localparam logic [NB_OP-1:0] C_SRL = NB_OP'(OP_SRL);

  state_e state_q, state_nxt;
  logic   load_pulse;

  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;

  logic [NB_DATA:0]          sum;
  logic [NB_DATA:0]          diff;
  logic signed [NB_DATA-1:0] sra_val;
  logic                      shamt_big;
  logic [NB_DATA-1:0]        alu_res;
  logic                      alu_carry;
  logic                      alu_ovf;
  logic                      alu_err;

  load_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_load_debounce (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_load),
    .o_pulse (load_pulse)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) state_q <= ST_LOAD_A;
    else          state_q <= state_nxt;
  end

  // NOTE: defaulting every always_comb output before the case keeps
  // unlisted paths from inferring latches.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_LOAD_A:  if (load_pulse) state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (load_pulse) state_nxt = ST_LOAD_OP;
      ST_LOAD_OP: if (load_pulse) state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_SHOW;
      ST_SHOW:    if (load_pulse) state_nxt = ST_LOAD_A;
      default:    state_nxt = ST_LOAD_A;
    endcase
  end

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  assign shamt_big = (b_q >= SHAMT_LIMIT);
  // Kept as its own signed assignment so >>> is not demoted to a logical shift.
  assign sra_val   = $signed(a_q) >>> b_q;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      C_ADD: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[NB_DATA];
        alu_ovf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      C_SUB: begin
        alu_res   = diff[MSB:0];
        alu_carry = diff[NB_DATA];
        alu_ovf   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      C_AND: alu_res = a_q & b_q;
      C_OR:  alu_res = a_q | b_q;
      C_XOR: alu_res = a_q ^ b_q;
      C_NOR: alu_res = ~(a_q | b_q);
      C_SRA: alu_res = shamt_big ? {NB_DATA{a_q[MSB]}} : sra_val;
      C_SRL: alu_res = shamt_big ? '0 : (a_q >> b_q);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_carry  <= 1'b0;
      o_ovf    <= 1'b0;
      o_err    <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A:  if (load_pulse) a_q  <= i_dato;
        ST_LOAD_B:  if (load_pulse) b_q  <= i_dato;
        ST_LOAD_OP: if (load_pulse) op_q <= i_dato[NB_OP-1:0];
        ST_EXEC: begin
          o_result <= alu_res;
          o_zero   <= (alu_res == '0);
          o_carry  <= alu_carry;
          o_ovf    <= alu_ovf;
          o_err    <= alu_err;
          o_valid  <= 1'b1;
        end
        ST_SHOW:    if (load_pulse) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table driven through the button
// sequence, scoreboard compared on each o_valid rise, plus debounce/reset cases.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int NB_DATA   = 8;
  localparam int NB_OP     = 6;
  localparam int DB_CYCLES = 4;

  logic               clk;
  logic               i_rst_n;
  logic [NB_DATA-1:0] i_dato;
  logic               i_load;
  logic [NB_DATA-1:0] o_result;
  logic               o_zero;
  logic               o_carry;
  logic               o_ovf;
  logic               o_err;
  logic               o_valid;
  logic [2:0]         o_state;

  alu_seq_ctrl #(
    .NB_DATA   (NB_DATA),
    .NB_OP     (NB_OP),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_dato   (i_dato),
    .i_load   (i_load),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_carry  (o_carry),
    .o_ovf    (o_ovf),
    .o_err    (o_err),
    .o_valid  (o_valid),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       e;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb_q[$];
  exp_t mexp;
  vec_t vecs[15];
  int   n_total  = 0;
  int   n_bad    = 0;
  int   n_seen   = 0;
  int   n_pushed = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every rising o_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (o_valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_unexpected: got result %0h with no pending expectation", o_result);
      end else begin
        mexp = sb_q.pop_front();
        n_seen++;
        check("result", o_result, mexp.res);
        check("zero",   o_zero,   mexp.z);
        check("carry",  o_carry,  mexp.c);
        check("ovf",    o_ovf,    mexp.v);
        check("err",    o_err,    mexp.e);
        check("state_at_valid", o_state, 3'd4);
      end
    end
    valid_prev = o_valid;
  end

  // One press: hold 10 cycles, release 10 cycles; starts and ends on a negedge.
  task automatic press(input logic [7:0] d);
    i_dato = d;
    i_load = 1'b1;
    repeat (10) @(negedge clk);
    i_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.z   = v.z;
    e.c   = v.c;
    e.v   = v.v;
    e.e   = v.e;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic run_seq(input vec_t v);
    press(v.a);
    check("state_load_b", o_state, 3'd1);
    press(v.b);
    check("state_load_op", o_state, 3'd2);
    push_exp(v);
    press({2'b00, v.op});
    check("seen_count", n_seen, n_pushed);
    check("state_show", o_state, 3'd4);
    check("valid_show", o_valid, 1'b1);
    press(8'h00);
    check("state_after_show", o_state, 3'd0);
    check("valid_cleared", o_valid, 1'b0);
    check("result_held", o_result, v.res);
  endtask

  task automatic glitch(input int len);
    i_dato = 8'hAA;
    i_load = 1'b1;
    repeat (len) @(negedge clk);
    i_load = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;

    vecs[0]  = '{8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{8'h05, 8'h05, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h03, 8'h05, OP_SUB, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h09, OP_SRA, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h09, OP_SRL, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'h02, OP_SRA, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 8'h04, OP_SRL, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'hC3, 8'h5A, OP_AND, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'hC3, 8'h5A, OP_OR,  8'hDB, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hC3, 8'h5A, OP_XOR, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'hC3, 8'h5A, OP_NOR, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h12, 8'h34, 6'h3F,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'h10, 8'h20, OP_ADD, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    i_rst_n = 1'b0;
    i_load  = 1'b0;
    i_dato  = '0;
    repeat (3) @(negedge clk);
    check("rst_state",  o_state,  3'd0);
    check("rst_result", o_result, 8'h00);
    check("rst_zero",   o_zero,   1'b0);
    check("rst_carry",  o_carry,  1'b0);
    check("rst_ovf",    o_ovf,    1'b0);
    check("rst_err",    o_err,    1'b0);
    check("rst_valid",  o_valid,  1'b0);
    i_rst_n = 1'b1;
    @(negedge clk);

    glitch(3);
    check("glitch3_state", o_state, 3'd0);
    glitch(1);
    check("glitch1_state", o_state, 3'd0);

    // A long hold must advance the FSM exactly once.
    i_dato = 8'h11;
    i_load = 1'b1;
    repeat (40) @(negedge clk);
    check("hold_state", o_state, 3'd1);
    i_load = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_release_state", o_state, 3'd1);
    press(8'h22);
    hv = '{8'h11, 8'h22, OP_ADD, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    push_exp(hv);
    press({2'b00, OP_ADD});
    check("hold_seen", n_seen, n_pushed);
    press(8'h00);
    check("hold_back_to_a", o_state, 3'd0);

    for (int i = 0; i < 15; i++) run_seq(vecs[i]);

    // Reset in LOAD_OP discards the partial sequence and clears flags.
    press(8'h12);
    press(8'h34);
    check("pre_rst_state", o_state, 3'd2);
    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    check("mid_rst_state",  o_state,  3'd0);
    check("mid_rst_valid",  o_valid,  1'b0);
    check("mid_rst_result", o_result, 8'h00);
    check("mid_rst_zero",   o_zero,   1'b0);
    check("mid_rst_carry",  o_carry,  1'b0);
    check("mid_rst_ovf",    o_ovf,    1'b0);
    check("mid_rst_err",    o_err,    1'b0);
    hv = '{8'h01, 8'h01, OP_ADD, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    run_seq(hv);

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
